// File: rtl/cmp_select_pkg.sv
// Shared defaults, stage count and stage-1 payload type for the cmp_select_pipe slice.
`timescale 1ns/1ps
package cmp_select_pkg;

    localparam int DATAWIDTH_DEFAULT = 32;
    localparam int CNTWIDTH_DEFAULT  = 16;
    localparam int NUM_STAGES        = 3;

    // Registered sums/difference handed from stage 1 to stage 2.
    typedef struct packed {
        logic [DATAWIDTH_DEFAULT-1:0] d;
        logic [DATAWIDTH_DEFAULT-1:0] e;
        logic [DATAWIDTH_DEFAULT-1:0] f;
    } stage2_payload_t;

endpackage

// File: rtl/cmp_select_pipe_if.sv
// Operand/result handshake bundle for cmp_select_pipe; the slave modport is the pipeline side.
`timescale 1ns/1ps
interface cmp_select_pipe_if
    import cmp_select_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEFAULT,
    parameter int CNTWIDTH  = CNTWIDTH_DEFAULT
);

    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] b;
    logic [DATAWIDTH-1:0] c;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] x;
    logic [DATAWIDTH-1:0] z;
    logic                 out_valid;
    logic                 out_ready;
    logic [CNTWIDTH-1:0]  count;

    modport master (
        output a, b, c, in_valid, out_ready,
        input  in_ready, x, z, out_valid, count
    );

    modport slave (
        input  a, b, c, in_valid, out_ready,
        output in_ready, x, z, out_valid, count
    );

endinterface

// File: rtl/cmp_select_pipe_sat_addsub.sv
// Adder/subtractor with optional saturation to the selected signedness range.
// Saturation is enabled by defining CMP_SELECT_PIPE_SAT_EN; otherwise results wrap.
`timescale 1ns/1ps
module sat_addsub #(
    parameter int DATAWIDTH = 32,
    parameter bit SIGNED    = 1'b1
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic                 sub,
    output logic [DATAWIDTH-1:0] y
);

`ifdef CMP_SELECT_PIPE_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic [DATAWIDTH:0] a_ext;
    logic [DATAWIDTH:0] b_ext;
    logic [DATAWIDTH:0] sum;
    logic               overflow;

    // One guard bit: signed overflow shows as disagreeing top bits, unsigned as carry/borrow.
    always_comb begin
        a_ext    = SIGNED ? {a[DATAWIDTH-1], a} : {1'b0, a};
        b_ext    = SIGNED ? {b[DATAWIDTH-1], b} : {1'b0, b};
        sum      = sub ? (a_ext - b_ext) : (a_ext + b_ext);
        overflow = SIGNED ? (sum[DATAWIDTH] != sum[DATAWIDTH-1]) : sum[DATAWIDTH];
        y        = sum[DATAWIDTH-1:0];
        if (SAT_EN && overflow) begin
            if (SIGNED) begin
                y = sum[DATAWIDTH] ? {1'b1, {(DATAWIDTH-1){1'b0}}}
                                   : {1'b0, {(DATAWIDTH-1){1'b1}}};
            end else begin
                y = sub ? '0 : '1;
            end
        end
    end

endmodule

// File: rtl/cmp_select_pipe.sv
// Three-stage add/compare/select/shift pipeline with valid/ready flow control and a
// delivered-result counter. CMP_SELECT_PIPE_SAT_EN selects saturating stage-1 arithmetic.
`timescale 1ns/1ps
module cmp_select_pipe
    import cmp_select_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEFAULT,
    parameter bit SIGNED    = 1'b1,
    parameter int CNTWIDTH  = CNTWIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst,
    cmp_select_pipe_if.slave bus
);

    localparam int NUM_UNITS = 3;

    logic [NUM_STAGES-1:0] valid_reg;
    logic [NUM_STAGES-1:0] valid_next;
    logic [NUM_STAGES-1:0] valid_feed;
    logic [NUM_STAGES-1:0] stage_ready;
    logic                  ready1;
    logic                  ready2;
    logic                  ready3;

    logic [DATAWIDTH-1:0]  op_b [NUM_UNITS];
    logic [DATAWIDTH-1:0]  unit_y [NUM_UNITS];

    stage2_payload_t       s1_reg;

    logic [DATAWIDTH-1:0]  g_next;
    logic [DATAWIDTH-1:0]  h_next;
    logic                  eq_next;
    logic                  lt_next;
    logic [DATAWIDTH-1:0]  g_reg;
    logic [DATAWIDTH-1:0]  h_reg;
    logic                  eq_reg;
    logic                  lt_reg;

    logic [DATAWIDTH-1:0]  x_reg;
    logic [DATAWIDTH-1:0]  z_reg;
    logic [CNTWIDTH-1:0]   count_reg;

    // A stage may load when empty or when the stage after it moves on this cycle.
    assign ready3      = !valid_reg[2] || bus.out_ready;
    assign ready2      = !valid_reg[1] || ready3;
    assign ready1      = !valid_reg[0] || ready2;
    assign stage_ready = {ready3, ready2, ready1};
    assign valid_feed  = {valid_reg[1:0], bus.in_valid};

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_valid
        assign valid_next[gi] = stage_ready[gi] ? valid_feed[gi] : valid_reg[gi];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_next;
        end
    end

    // Units 0..2 produce a+b, a+c and a-b.
    assign op_b[0] = bus.b;
    assign op_b[1] = bus.c;
    assign op_b[2] = bus.b;

    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_addsub
        sat_addsub #(
            .DATAWIDTH (DATAWIDTH),
            .SIGNED    (SIGNED)
        ) u_addsub (
            .a   (bus.a),
            .b   (op_b[gi]),
            .sub (gi == NUM_UNITS - 1),
            .y   (unit_y[gi])
        );
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1_reg <= '0;
        end else if (bus.in_valid && ready1) begin
            s1_reg.d <= unit_y[0];
            s1_reg.e <= unit_y[1];
            s1_reg.f <= unit_y[2];
        end
    end

    always_comb begin
        eq_next = (s1_reg.d == s1_reg.e);
        lt_next = SIGNED ? ($signed(s1_reg.d) < $signed(s1_reg.e)) : (s1_reg.d < s1_reg.e);
        g_next  = lt_next ? s1_reg.d : s1_reg.e;
        h_next  = eq_next ? g_next : s1_reg.f;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            g_reg  <= '0;
            h_reg  <= '0;
            eq_reg <= 1'b0;
            lt_reg <= 1'b0;
        end else if (valid_reg[0] && ready2) begin
            g_reg  <= g_next;
            h_reg  <= h_next;
            eq_reg <= eq_next;
            lt_reg <= lt_next;
        end
    end

    // Output stage only reloads when it can move, so x/z hold under backpressure.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            x_reg <= '0;
            z_reg <= '0;
        end else if (valid_reg[1] && ready3) begin
            x_reg <= g_reg << lt_reg;
            z_reg <= h_reg >> eq_reg;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            count_reg <= '0;
        end else if (valid_reg[2] && bus.out_ready) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign bus.in_ready  = ready1;
    assign bus.out_valid = valid_reg[2];
    assign bus.x         = x_reg;
    assign bus.z         = z_reg;
    assign bus.count     = count_reg;

endmodule

// File: tb/tb_cmp_select_pipe.sv
// Self-checking bench for cmp_select_pipe: directed vector table, backpressure, reset,
// counter wrap and randomized traffic against an arithmetic reference model.
`timescale 1ns/1ps
module tb_cmp_select_pipe;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    cmp_select_pipe_if #(.DATAWIDTH(32), .CNTWIDTH(16)) bus ();
    cmp_select_pipe_if #(.DATAWIDTH(32), .CNTWIDTH(4))  bus4 ();

    cmp_select_pipe #(.DATAWIDTH(32), .SIGNED(1'b1), .CNTWIDTH(16)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    cmp_select_pipe #(.DATAWIDTH(32), .SIGNED(1'b1), .CNTWIDTH(4)) dut4 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus4)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] x;
        logic [31:0] z;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    logic [15:0] exp_count = '0;
    logic [63:0] sb_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Signed reference: wide integer arithmetic, then clamp or wrap to 32 bits.
    function automatic longint fit32(input longint v);
        logic [31:0] t;
`ifdef CMP_SELECT_PIPE_SAT_EN
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
`else
        t = v[31:0];
        return longint'($signed(t));
`endif
    endfunction

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
        longint      sa, sb, sc, d, e, f, g, h;
        logic [31:0] xr, zr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sc = longint'($signed(c));
        d  = fit32(sa + sb);
        e  = fit32(sa + sc);
        f  = fit32(sa - sb);
        g  = (d < e) ? d : e;
        h  = (d == e) ? g : f;
        xr = (d < e) ? 32'(g * 2) : 32'(g);
        zr = 32'(h);
        if (d == e) zr = zr / 2;
        return {xr, zr};
    endfunction

    function automatic logic [31:0] rand32();
        case ($urandom_range(7))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h0000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        bus.a = a;
        bus.b = b;
        bus.c = c;
    endtask

    // Scoreboard: records accepted operands and checks each delivered result in order.
    always @(negedge Clk) begin
        logic [63:0] exp;
        if (Rst) begin
            sb_q.delete();
            exp_count = '0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                $display("out %0d x=%08h z=%08h count=%0d", delivered, bus.x, bus.z, bus.count);
                delivered++;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_result", 64'd1, 64'd0);
                end else begin
                    exp = sb_q.pop_front();
                    check("sb_x", {32'd0, bus.x}, {32'd0, exp[63:32]});
                    check("sb_z", {32'd0, bus.z}, {32'd0, exp[31:0]});
                end
                check("sb_count", {48'd0, bus.count}, {48'd0, exp_count});
                exp_count = exp_count + 16'd1;
            end
            if (bus.in_valid && bus.in_ready) sb_q.push_back(model(bus.a, bus.b, bus.c));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [4];
        vec_t        pb [5];
        logic [63:0] exp;
        int          k;
        int          stale;
        int          acc4;
        int          waited;

        tbl[0] = '{32'd5, 32'd3, 32'd1, 32'd6, 32'd2};
        tbl[1] = '{32'd4, 32'd2, 32'd2, 32'd6, 32'd3};
        tbl[2] = '{32'd1, 32'd1, 32'd5, 32'd4, 32'd0};
`ifdef CMP_SELECT_PIPE_SAT_EN
        tbl[3] = '{32'h7FFF_FFFF, 32'd1, 32'd0, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
`else
        tbl[3] = '{32'h7FFF_FFFF, 32'd1, 32'd0, 32'h0000_0000, 32'h7FFF_FFFE};
`endif

        drive(32'd0, 32'd0, 32'd0);
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus4.a         = '0;
        bus4.b         = '0;
        bus4.c         = '0;
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;

        // Reset state
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check("rst_count",     {48'd0, bus.count},     64'd0);
        check("rst_x",         {32'd0, bus.x},         64'd0);
        check("rst_z",         {32'd0, bus.z},         64'd0);

        // Directed vectors: single transfers with exact three-cycle latency
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk);
            #1;
            drive(tbl[i].a, tbl[i].b, tbl[i].c);
            bus.in_valid = 1'b1;
            @(negedge Clk);
            check("tbl_in_ready", {63'd0, bus.in_ready}, 64'd1);
            @(posedge Clk);
            #1 bus.in_valid = 1'b0;
            @(negedge Clk);
            check("tbl_latency_1", {63'd0, bus.out_valid}, 64'd0);
            @(posedge Clk);
            @(negedge Clk);
            check("tbl_latency_2", {63'd0, bus.out_valid}, 64'd0);
            @(posedge Clk);
            @(negedge Clk);
            check("tbl_out_valid", {63'd0, bus.out_valid}, 64'd1);
            check("tbl_x", {32'd0, bus.x}, {32'd0, tbl[i].x});
            check("tbl_z", {32'd0, bus.z}, {32'd0, tbl[i].z});
            @(posedge Clk);
            @(negedge Clk);
            check("tbl_count", {48'd0, bus.count}, 64'(i + 1));
        end

        // Backpressure: five back-to-back inputs, only three fit while stalled
        for (int i = 0; i < 5; i++) pb[i] = '{rand32(), rand32(), rand32(), 32'd0, 32'd0};
        exp = model(pb[0].a, pb[0].b, pb[0].c);
        k = 0;
        bus.out_ready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(posedge Clk);
            #1;
            bus.in_valid = (k < 5);
            if (k < 5) drive(pb[k].a, pb[k].b, pb[k].c);
            @(negedge Clk);
            if (cyc >= 4) begin
                check("bp_hold_x", {32'd0, bus.x}, {32'd0, exp[63:32]});
                check("bp_hold_z", {32'd0, bus.z}, {32'd0, exp[31:0]});
            end
            if (bus.in_valid && bus.in_ready) k++;
        end
        check("bp_accepted", 64'(k), 64'd3);
        check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(posedge Clk);
            #1;
            bus.out_ready = 1'b1;
            bus.in_valid  = (k < 5);
            if (k < 5) drive(pb[k].a, pb[k].b, pb[k].c);
            @(negedge Clk);
            exp = model(pb[cyc].a, pb[cyc].b, pb[cyc].c);
            check("bp_stream_valid", {63'd0, bus.out_valid}, 64'd1);
            check("bp_stream_x", {32'd0, bus.x}, {32'd0, exp[63:32]});
            check("bp_stream_z", {32'd0, bus.z}, {32'd0, exp[31:0]});
            if (bus.in_valid && bus.in_ready) k++;
        end
        check("bp_all_accepted", 64'(k), 64'd5);

        // Reset with two results in flight and an input offered during reset
        @(posedge Clk);
        #1;
        drive(32'd10, 32'd20, 32'd30);
        bus.in_valid = 1'b1;
        @(posedge Clk);
        #1 drive(32'd40, 32'd50, 32'd60);
        @(posedge Clk);
        #1;
        drive(32'd70, 32'd80, 32'd90);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge Clk);
        check("rst_mid_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_mid_count", {48'd0, bus.count}, 64'd0);
        check("rst_mid_in_ready", {63'd0, bus.in_ready}, 64'd1);
        stale = 0;
        repeat (6) begin
            @(negedge Clk);
            if (bus.out_valid) stale++;
        end
        check("rst_no_stale", 64'(stale), 64'd0);

        // Randomized traffic with random backpressure against the scoreboard
        for (int n = 0; n < 400; n++) begin
            @(posedge Clk);
            #1;
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.out_ready = ($urandom_range(2) != 0);
            bus.a = rand32();
            bus.b = rand32();
            bus.c = ($urandom_range(3) == 0) ? bus.b : rand32();
        end
        @(posedge Clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        waited = 0;
        while (sb_q.size() != 0 && waited < 20) begin
            @(negedge Clk);
            waited++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);

        // Counter wrap on the 4-bit instance: 17 results leave count at 1
        acc4 = 0;
        for (int cyc = 0; cyc < 60 && acc4 < 17; cyc++) begin
            @(posedge Clk);
            #1;
            bus4.in_valid = 1'b1;
            bus4.a = 32'(cyc);
            bus4.b = 32'd3;
            bus4.c = 32'd7;
            @(negedge Clk);
            if (bus4.in_valid && bus4.in_ready) acc4++;
        end
        @(posedge Clk);
        #1 bus4.in_valid = 1'b0;
        repeat (6) @(posedge Clk);
        @(negedge Clk);
        check("wrap_accepted", 64'(acc4), 64'd17);
        check("wrap_count", {60'd0, bus4.count}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_select_pipe.md
CMP_SELECT_PIPE -- requirements
Module: cmp_select_pipe

Interface
REQ-001 Parameter DATAWIDTH, default 32: width of operands a, b, c and results x, z.
REQ-002 Parameter SIGNED, default 1: 1 selects two's-complement add/sub/compare; 0 selects unsigned.
REQ-003 Parameter CNTWIDTH, default 16: width of the completed-result counter.
REQ-004 Port Clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port Rst, input, 1: reset, synchronous and active-high.
REQ-006 Port a, b, c, inputs, DATAWIDTH each: operands.
REQ-007 Port in_valid, input, 1: operands present this cycle.
REQ-008 Port in_ready, output, 1: block accepts operands this cycle.
REQ-009 Port x, z, outputs, DATAWIDTH each: results.
REQ-010 Port out_valid, output, 1: x and z hold a result.
REQ-011 Port out_ready, input, 1: consumer takes the result this cycle.
REQ-012 Port count, output, CNTWIDTH: number of results delivered since reset.

Function
REQ-013 The block SHALL be a three-stage pipeline; an input accepted in cycle N SHALL appear at x/z with out_valid=1 in cycle N+3 when there is no backpressure.
REQ-014 Stage 1 SHALL register d=a+b, e=a+c, f=a-b, each truncated to DATAWIDTH (wrap-around).
REQ-015 Stage 2 SHALL register eq=(d==e), lt=(d<e) per SIGNED, g = lt ? d : e, and h = eq ? g : f.
REQ-016 Stage 3 SHALL register x = g << lt and z = h >> eq; shifts are logical and zero-filled.
REQ-017 Each stage SHALL hold a valid bit; a stage SHALL load when it is empty or when its successor advances in the same cycle.
REQ-018 in_ready SHALL be combinational: in_ready = !v1 | stage-1 advancing. Transfer occurs when in_valid & in_ready.
REQ-019 With out_valid=1 and out_ready=0, x, z and out_valid SHALL hold stable; upstream stages SHALL fill bubbles until all three are full.
REQ-020 Results SHALL leave in acceptance order; nothing SHALL be dropped or duplicated.
REQ-021 count SHALL increment by 1 on each out_valid & out_ready cycle and wrap from 2^CNTWIDTH-1 to 0.
REQ-022 When the pipeline is full and drains in the same cycle, a simultaneous input SHALL be accepted; full throughput is one result per cycle.

Reset
REQ-023 While Rst=1 at a clock edge, all valid bits, all stage registers, x, z and count SHALL clear to 0; out_valid=0 and in_ready=1 in the following cycle.
REQ-024 Reset mid-operation SHALL discard in-flight data; inputs presented while Rst=1 SHALL NOT be accepted.

Configuration
REQ-025 Macro CMP_SELECT_PIPE_SAT_EN defined: stage-1 add/sub SHALL saturate to the min/max of the selected signedness.
REQ-026 Macro CMP_SELECT_PIPE_SAT_EN undefined: stage-1 add/sub SHALL wrap modulo 2^DATAWIDTH; there SHALL be no other difference.

Structure
REQ-027 Package cmp_select_pkg SHALL hold the DATAWIDTH and CNTWIDTH defaults, the localparam NUM_STAGES=3 and the stage-2 payload struct {d,e,f} typedef.
REQ-028 Add/sub with optional saturation SHALL be the single sub-module sat_addsub (ports: a, b, sub, y), instantiated three times.

Verification (DATAWIDTH=32, SIGNED=1, out_ready=1 unless stated)
REQ-029 a=5, b=3, c=1 -> after 3 cycles x=6, z=2, count=1.
REQ-030 a=4, b=2, c=2 (eq) -> x=6, z=3; then a=1, b=1, c=5 (lt) -> x=4, z=0.
REQ-031 a=0x7FFFFFFF, b=1, c=0: macro off -> x=0, z=0x7FFFFFFE; macro on -> x=0x7FFFFFFF, z=0x3FFFFFFF.
REQ-032 out_ready=0 with 5 back-to-back inputs -> 3 accepted, then in_ready=0 and outputs held; out_ready=1 -> all 5 results delivered in order at 1 per cycle.
REQ-033 Rst=1 pulsed with 2 results in flight -> out_valid=0 and count=0 next cycle; no stale result emerges afterwards.
REQ-034 CNTWIDTH=4, 17 results delivered -> count=1.
